acc_mem_responder: RTL and testbench
====================================

ACC_MEM_RESPONDER -- requirements
Module: acc_mem_responder

Interface
- REQ-001 Parameter DEPTH, default 4096, number of 32-bit elements in local storage.
- REQ-002 Parameter IDX_W, default 32, width of element index.
- REQ-003 clk  input  1  sole clock; all state updates on rising edge.
- REQ-004 rst  input  1  reset, asynchronous, active-high.
- REQ-005 req_valid  input  1  request present.
- REQ-006 req_ready  output  1  responder can accept a request.
- REQ-007 req_we  input  1  1 = masked write, 0 = burst read.
- REQ-008 req_idx  input  IDX_W  starting 32-bit element index.
- REQ-009 req_len  input  4  element count; 0 means 16.
- REQ-010 req_wdata  input  512  write line; element i at bits [32i+31:32i].
- REQ-011 req_wmask  input  512  bitwise write enable, same layout.
- REQ-012 rsp_valid  output  1  response present.
- REQ-013 rsp_ready  input  1  initiator accepts response.
- REQ-014 rsp_rdata  output  512  read line, element i at [32i+31:32i]; unused elements 0.
- REQ-015 rsp_err  output  1  at least one element index was >= DEPTH.

Function
- REQ-016 FSM states IDLE, BUSY, RESP; only IDLE asserts req_ready.
- REQ-017 IDLE -> BUSY when req_valid && req_ready; req_we, req_idx, effective length L (1..16), req_wdata, req_wmask captured that edge.
- REQ-018 BUSY processes one element per cycle, element counter cnt from 0 to L-1; element address = captured idx + cnt, computed at IDX_W+1 bits (no wrap).
- REQ-019 Read: element cnt of storage loaded into rdata line slot cnt; slots >= L held 0.
- REQ-020 Write: storage[addr] <= (old & ~mask_cnt) | (wdata_cnt & mask_cnt); all-zero mask_cnt leaves element unchanged.
- REQ-021 Address >= DEPTH: read slot returns 0, write dropped, sticky err flag set for this transaction.
- REQ-022 BUSY -> RESP on the cycle cnt = L-1 completes; request-to-rsp_valid latency exactly L+1 cycles.
- REQ-023 RESP holds rsp_valid, rsp_rdata, rsp_err stable until rsp_valid && rsp_ready, then -> IDLE.
- REQ-024 Write response: rsp_rdata = 0, rsp_err per REQ-021.
- REQ-025 Earliest next accept is the cycle after the response handshake; req_valid ignored outside IDLE.
- REQ-026 rsp_valid never asserted in IDLE or BUSY; rsp_rdata, rsp_err are 0 in IDLE.
- REQ-027 Storage not cleared by reset; read of unwritten element returns its power-up value (bench preloads).

Reset
- REQ-028 rst asserted: state -> IDLE, cnt, captured fields, err, rdata line -> 0 immediately, without clock.
- REQ-029 Reset outputs: req_ready=1 after release, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- REQ-030 rst mid-BUSY aborts transaction; writes of elements already processed remain, no response issued.

Structure
- REQ-031 Package acc_mem_pkg holds LINE_W=512, ELEM_W=32, ELEMS_PER_LINE=16, FSM state encoding.
- REQ-032 One sub-module acc_mem_array: DEPTH x 32 storage, one combinational read port, one synchronous bit-masked write port.

Verification
- REQ-033 Preload storage[100..115]=100..115; read idx=100 len=0 -> rsp_valid after 17 cycles, slot i = 100+i, err=0.
- REQ-034 Write idx=8 len=3 wdata slots = 0xAAAA_AAAA, mask slot1 = 0x0000_FFFF else all ones, storage old 0 -> then read len=3 gives 0xAAAAAAAA, 0x0000AAAA, 0xAAAAAAAA, slots 3..15 = 0.
- REQ-035 Read idx=DEPTH-2 len=4 -> slots 0,1 data, slots 2,3 = 0, rsp_err=1; following in-range read -> err=0.
- REQ-036 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable, req_ready=0, new req_valid ignored; release -> IDLE next cycle.
- REQ-037 Assert rst at cnt=2 of a len=8 write -> outputs reset same cycle, elements 0..1 (or 0..2 if edge completed) written, no response; next read succeeds.
- REQ-038 Back-to-back: read len=1 with rsp_ready tied 1 -> rsp_valid at cycle 2, req_ready high cycle 3, second request accepted cycle 3.

Source files
------------

// File: rtl/acc_mem_pkg.sv
// acc_mem_pkg: shared widths, line type and FSM encoding for the responder
package acc_mem_pkg;
  localparam int LINE_W = 512;
  localparam int ELEM_W = 32;
  localparam int ELEMS_PER_LINE = 16;
  typedef logic [ELEMS_PER_LINE-1:0][ELEM_W-1:0] line_t;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
endpackage

// File: rtl/acc_mem_responder_if.sv
// acc_mem_responder_if: valid/ready request + response bus; master = initiator, slave = responder
interface acc_mem_responder_if #(parameter int IDX_W = 32);
  import acc_mem_pkg::*;
  logic req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [IDX_W-1:0] req_idx;
  logic [3:0] req_len;
  logic [LINE_W-1:0] req_wdata, req_wmask, rsp_rdata;
  modport master(
    output req_valid, req_we, req_idx, req_len, req_wdata, req_wmask, rsp_ready,
    input req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave(
    input req_valid, req_we, req_idx, req_len, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/acc_mem_array.sv
// acc_mem_array: DEPTH x 32 storage; ports clk, combinational read (rd_addr/rd_data), bit-masked sync write (wr_*)
module acc_mem_array
  import acc_mem_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW = 12
) (
  input  logic              clk,
  input  logic [AW-1:0]     rd_addr,
  output logic [ELEM_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [ELEM_W-1:0] wr_data,
  input  logic [ELEM_W-1:0] wr_mask
);
  logic [ELEM_W-1:0] mem [DEPTH];
  assign rd_data = mem[rd_addr];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= (mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
endmodule

// File: rtl/acc_mem_responder.sv
// acc_mem_responder: one-element-per-cycle masked-write / burst-read responder; ports clk, rst, bus (slave modport)
module acc_mem_responder
  import acc_mem_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int IDX_W = 32
) (
  input logic clk,
  input logic rst,
  acc_mem_responder_if.slave bus
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  state_t state;
  logic we, err, in_range;
  logic [IDX_W-1:0] idx;
  logic [IDX_W:0] addr;
  logic [4:0] len;
  logic [3:0] cnt;
  line_t wdata, wmask, rdata;
  logic [ELEM_W-1:0] rd_data;
  // one extra address bit so idx + cnt never wraps back into range
  assign addr = {1'b0, idx} + (IDX_W+1)'(cnt);
  assign in_range = addr < (IDX_W+1)'(DEPTH);
  assign bus.req_ready = state == IDLE;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_rdata = rdata;
  assign bus.rsp_err = err;
  acc_mem_array #(.DEPTH(DEPTH), .AW(AW)) u_arr (
    .clk(clk),
    .rd_addr(addr[AW-1:0]),
    .rd_data(rd_data),
    .wr_en(state == BUSY && we && in_range),
    .wr_addr(addr[AW-1:0]),
    .wr_data(wdata[cnt]),
    .wr_mask(wmask[cnt])
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      we <= 1'b0;
      idx <= '0;
      len <= '0;
      cnt <= '0;
      wdata <= '0;
      wmask <= '0;
      rdata <= '0;
      err <= 1'b0;
    end else
      case (state)
        IDLE: if (bus.req_valid) begin
          state <= BUSY;
          we <= bus.req_we;
          idx <= bus.req_idx;
          len <= bus.req_len == 4'd0 ? 5'd16 : {1'b0, bus.req_len};
          cnt <= '0;
          wdata <= bus.req_wdata;
          wmask <= bus.req_wmask;
          rdata <= '0;
          err <= 1'b0;
        end
        BUSY: begin
          if (!we) rdata[cnt] <= in_range ? rd_data : '0;
          err <= err | ~in_range;
          cnt <= cnt + 4'd1;
          if ({1'b0, cnt} == len - 5'd1) state <= RESP;
        end
        RESP: if (bus.rsp_ready) begin
          state <= IDLE;
          rdata <= '0;
          err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_acc_mem_responder.sv
// tb_acc_mem_responder: randomized + directed bench against a transaction-level memory model
module tb_acc_mem_responder;
  import acc_mem_pkg::*;
  localparam int DEPTH = 256;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  acc_mem_responder_if #(.IDX_W(32)) bus();
  acc_mem_responder #(.DEPTH(DEPTH), .IDX_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_chk = 0, n_pass = 0;
  typedef struct {int cyc; int a; logic [31:0] d; logic [31:0] m;} wr_t;
  wr_t wr_q[$];
  logic [31:0] mem_m [DEPTH];
  int cyc = 0, due = 0;
  bit pending = 0, started = 0;
  logic [511:0] exp_rd;
  logic exp_err;

  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
  endtask

  function automatic logic [31:0] pre(int i);
    return (i >= 100 && i < 116) ? 32'(i) : (i >= 8 && i < 11) ? 32'd0 : 32'(i) * 32'h9E3779B1;
  endfunction

  // model: a request accepted in cycle c answers in cycle c+L+1 until handshaken;
  // element k of a write lands on the clock edge closing cycle c+1+k
  always @(negedge clk) begin
    wr_t w;
    int len;
    longint a;
    cyc++;
    while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
      w = wr_q.pop_front();
      mem_m[w.a] = (mem_m[w.a] & ~w.m) | (w.d & w.m);
    end
    if (rst) begin
      wr_q.delete();
      pending = 0;
      started = 1;
    end
    if (started) begin
      chk("req_ready", bus.req_ready, !pending);
      chk("rsp_valid", bus.rsp_valid, pending && cyc >= due);
      if (!pending || cyc >= due) begin
        chk("rsp_rdata", bus.rsp_rdata, pending ? exp_rd : '0);
        chk("rsp_err", bus.rsp_err, pending ? exp_err : 1'b0);
      end
    end
    if (started && !rst) begin
      if (pending) begin
        if (cyc >= due && bus.rsp_ready) pending = 0;
      end else if (bus.req_valid) begin
        len = bus.req_len == 0 ? 16 : int'(bus.req_len);
        exp_rd = '0;
        exp_err = 0;
        pending = 1;
        due = cyc + len + 1;
        for (int k = 0; k < len; k++) begin
          a = longint'(bus.req_idx) + k;
          if (a >= DEPTH) exp_err = 1;
          else if (bus.req_we) wr_q.push_back('{cyc + 1 + k, int'(a), bus.req_wdata[32*k +: 32], bus.req_wmask[32*k +: 32]});
          else exp_rd[32*k +: 32] = mem_m[a];
        end
      end
    end
  end

  task automatic txn(input logic we, input logic [31:0] idx, input logic [3:0] len,
                     input logic [511:0] wd, input logic [511:0] wm, input int hold,
                     output logic [511:0] rd, output logic er, output int lat);
    bus.req_we = we;
    bus.req_idx = idx;
    bus.req_len = len;
    bus.req_wdata = wd;
    bus.req_wmask = wm;
    bus.req_valid = 1;
    bus.rsp_ready = hold == 0;
    @(posedge clk); #1;
    bus.req_valid = 0;
    lat = 1;
    while (!bus.rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("rsp_arrives", bus.rsp_valid, 1'b1);
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    repeat (hold) begin
      bus.req_valid = 1;
      bus.req_we = 1'($urandom);
      bus.req_idx = $urandom_range(0, DEPTH - 1);
      bus.req_len = 4'($urandom);
      bus.req_wmask = '1;
      @(posedge clk); #1;
    end
    bus.req_valid = 0;
    bus.rsp_ready = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [511:0] rd, wd, wm, ex;
    logic er;
    int lat, sel;
    logic [31:0] ridx;
    bus.req_valid = 0; bus.req_we = 0; bus.req_idx = 0; bus.req_len = 0;
    bus.req_wdata = 0; bus.req_wmask = 0; bus.rsp_ready = 0;
    #1 rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("reset_req_ready", bus.req_ready, 1'b1);
    chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
    chk("reset_rsp_rdata", bus.rsp_rdata, '0);
    for (int b = 0; b < DEPTH / 16; b++) begin
      for (int i = 0; i < 16; i++) wd[32*i +: 32] = pre(b * 16 + i);
      txn(1, 32'(b * 16), 4'd0, wd, '1, 0, rd, er, lat);
    end
    // 16-element read of the known ramp
    txn(0, 100, 4'd0, '0, '0, 0, rd, er, lat);
    chk("ramp_latency", 32'(lat), 32'd17);
    chk("ramp_err", er, 1'b0);
    for (int i = 0; i < 16; i++) chk("ramp_slot", rd[32*i +: 32], 32'(100 + i));
    // masked write then read back
    wd = {16{32'hAAAA_AAAA}};
    wm = '1;
    wm[63:32] = 32'h0000_FFFF;
    txn(1, 8, 4'd3, wd, wm, 0, rd, er, lat);
    chk("write_rsp_rdata", rd, '0);
    chk("write_latency", 32'(lat), 32'd4);
    txn(0, 8, 4'd3, '0, '0, 0, rd, er, lat);
    ex = '0;
    ex[95:0] = {32'hAAAA_AAAA, 32'h0000_AAAA, 32'hAAAA_AAAA};
    chk("masked_readback", rd, ex);
    // straddling the top of storage
    txn(0, DEPTH - 2, 4'd4, '0, '0, 0, rd, er, lat);
    chk("edge_err", er, 1'b1);
    chk("edge_oob_slots", rd[127:64], 64'd0);
    chk("edge_data", rd[63:0], {pre(DEPTH - 1), pre(DEPTH - 2)});
    txn(0, 0, 4'd2, '0, '0, 0, rd, er, lat);
    chk("err_cleared", er, 1'b0);
    // response held by backpressure while new requests are offered
    txn(0, 100, 4'd2, '0, '0, 5, rd, er, lat);
    chk("held_data", rd[63:0], {32'd101, 32'd100});
    // back-to-back single reads
    txn(0, 5, 4'd1, '0, '0, 0, rd, er, lat);
    chk("b2b_latency0", 32'(lat), 32'd2);
    txn(0, 6, 4'd1, '0, '0, 0, rd, er, lat);
    chk("b2b_latency1", 32'(lat), 32'd2);
    // reset during the third element of an 8-element write
    bus.req_we = 1; bus.req_idx = 40; bus.req_len = 4'd8;
    bus.req_wdata = {16{32'h1234_5678}}; bus.req_wmask = '1;
    bus.req_valid = 1; bus.rsp_ready = 1;
    @(posedge clk); #1;
    bus.req_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    #1;
    chk("abort_req_ready", bus.req_ready, 1'b1);
    chk("abort_rsp_valid", bus.rsp_valid, 1'b0);
    @(posedge clk); #1 rst = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_rsp", bus.rsp_valid, 1'b0);
    txn(0, 40, 4'd8, '0, '0, 0, rd, er, lat);
    chk("abort_elem0", rd[31:0], 32'h1234_5678);
    chk("abort_elem1", rd[63:32], 32'h1234_5678);
    chk("abort_elem2", rd[95:64], pre(42));
    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 9);
      ridx = sel < 6 ? $urandom_range(0, DEPTH - 1) : sel < 9 ? $urandom_range(DEPTH - 10, DEPTH + 2) : 32'hFFFF_FFF8;
      for (int i = 0; i < 16; i++) begin
        wd[32*i +: 32] = $urandom;
        sel = $urandom_range(0, 2);
        wm[32*i +: 32] = sel == 0 ? 32'd0 : sel == 1 ? 32'hFFFF_FFFF : $urandom;
      end
      txn(1'($urandom), ridx, 4'($urandom), wd, wm, $urandom_range(0, 3), rd, er, lat);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
